// File: rtl/spi_op_pkg.sv
// spi_op_pkg: state encoding, opcodes and sizing helper
// shared by the operation arbiter and the shift/ALU slave.
package spi_op_pkg;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] OP_SHL = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_SHR = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_A,
    SEND_B,
    EXEC_WAIT,
    RECV,
    DONE,
    GUARD
  } state_t;

  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_op_arbiter_if.sv
// spi_op_arbiter_if: per-requester operation handshake
// plus the shared completion bus.
interface spi_op_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int REG_WIDTH = 32
);
  import spi_op_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][OPCODE_W-1:0]  req_opcode;
  logic [NUM_REQ-1:0][REG_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][REG_WIDTH-1:0] req_b;
  logic                              rsp_valid;
  logic [ID_W-1:0]                   rsp_id;
  logic [REG_WIDTH-1:0]              rsp_data;

  modport master (
    output req_valid, req_opcode, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/spi_bit_engine.sv
// spi_bit_engine: per-bit sclk timing, MSB-first shift
// register and bit counter for one SPI field.
module spi_bit_engine #(
  parameter int REG_WIDTH = 32,
  parameter int SCLK_LOW  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 run,
  input  logic [REG_WIDTH-1:0] load_val,
  input  logic [5:0]           last_idx,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 last,
  output logic [REG_WIDTH-1:0] rx_word
);

  localparam int PW = $clog2(SCLK_LOW + 1);

  logic [PW-1:0]        phase_q;
  logic [5:0]           cnt_q;
  logic [REG_WIDTH-1:0] sr_q;
  logic                 hi;

  assign hi      = run && (phase_q == PW'(SCLK_LOW));
  assign sclk    = hi;
  assign mosi    = run && sr_q[REG_WIDTH-1];
  assign last    = hi && (cnt_q == last_idx);
  assign rx_word = {sr_q[REG_WIDTH-2:0], miso};

  // Phase/bit counters and shift register; one shift per sclk-high cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else if (load) begin
      phase_q <= '0;
      cnt_q   <= '0;
      sr_q    <= load_val;
    end else if (run) begin
      if (hi) begin
        phase_q <= '0;
        cnt_q   <= cnt_q + 6'd1;
        sr_q    <= rx_word;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_op_arbiter.sv
// spi_op_arbiter: round-robin arbiter that ships one
// opcode/A/B operation over SPI and returns the result.
module spi_op_arbiter
  import spi_op_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int REG_WIDTH = 32,
  parameter int SCLK_LOW  = 3,
  parameter int EXEC_GAP  = 4
) (
  input  logic            clock,
  input  logic            reset,
  spi_op_arbiter_if.slave bus,
  output logic            sclk,
  output logic            nss,
  output logic            mosi,
  input  logic            miso,
  output logic            busy
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam int GW   = $clog2(EXEC_GAP + 2) + 1;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, gnt_idx, own_q, nxt_ptr;
  logic [ID_W:0]        cand;
  logic                 gnt_any, gnt_fire;
  logic                 load, run, last, eng_mosi;
  logic [5:0]           last_idx;
  logic [GW-1:0]        gap_q;
  logic [REG_WIDTH-1:0] a_q, b_q, load_val, rx_word;
  logic [ID_W-1:0]      rsp_id_q;
  logic [REG_WIDTH-1:0] rsp_data_q;

  // Round-robin pick: first valid index at or after the pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      if (bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  assign gnt_fire = (state_q == IDLE) && gnt_any && !reset;
  assign nxt_ptr  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                  : gnt_idx + 1'b1;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: field ends are signalled by the bit engine.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (gnt_fire) state_d = SEND_OP;
      SEND_OP:   if (last) state_d = SEND_A;
      SEND_A:    if (last) state_d = SEND_B;
      SEND_B:    if (last) state_d = EXEC_WAIT;
      EXEC_WAIT: if (gap_q == GW'(EXEC_GAP - 1)) state_d = RECV;
      RECV:      if (last) state_d = DONE;
      DONE:      state_d = GUARD;
      GUARD:     if (gap_q == GW'(1)) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: chip select, handshake, engine control and field payload.
  always_comb begin
    run           = 1'b0;
    nss           = 1'b1;
    busy          = gnt_fire;
    bus.rsp_valid = 1'b0;
    bus.req_ready = '0;
    if (gnt_fire) bus.req_ready[gnt_idx] = 1'b1;
    unique case (state_q)
      SEND_OP, SEND_A, SEND_B, RECV: begin
        run  = 1'b1;
        nss  = 1'b0;
        busy = 1'b1;
      end
      EXEC_WAIT: begin
        nss  = 1'b0;
        busy = 1'b1;
      end
      DONE: begin
        busy          = 1'b1;
        bus.rsp_valid = 1'b1;
      end
      default: ;
    endcase
    last_idx = (state_q == SEND_OP) ? 6'd3
             : 6'(REG_WIDTH - 1);
    load     = (state_d != state_q);
    load_val = '0;
    unique case (state_d)
      SEND_OP: load_val = {bus.req_opcode[gnt_idx],
                           {(REG_WIDTH-OPCODE_W){1'b0}}};
      SEND_A:  load_val = a_q;
      SEND_B:  load_val = b_q;
      default: load_val = '0;
    endcase
    mosi = eng_mosi && (state_q != RECV);
  end

  // Wait counter for the execution gap and the nss guard.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      gap_q <= '0;
    else if (state_d != state_q)
      gap_q <= '0;
    else if (state_q == EXEC_WAIT || state_q == GUARD)
      gap_q <= gap_q + 1'b1;
  end

  // Operand capture at grant, result/owner capture on the last bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      own_q      <= '0;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      if (gnt_fire) begin
        a_q   <= bus.req_a[gnt_idx];
        b_q   <= bus.req_b[gnt_idx];
        own_q <= gnt_idx;
        ptr_q <= nxt_ptr;
      end
      if (state_q == RECV && last) begin
        rsp_id_q   <= own_q;
        rsp_data_q <= rx_word;
      end
    end
  end

  assign bus.rsp_id   = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;

  spi_bit_engine #(
    .REG_WIDTH (REG_WIDTH),
    .SCLK_LOW  (SCLK_LOW)
  ) u_eng (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .run      (run),
    .load_val (load_val),
    .last_idx (last_idx),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (eng_mosi),
    .last     (last),
    .rx_word  (rx_word)
  );

endmodule

// File: tb/tb_spi_op_arbiter.sv
// tb_spi_op_arbiter: directed scenarios against a behavioural
// SPI shift/ALU slave, plus a per-cycle protocol monitor.
module tb_spi_op_arbiter;
  import spi_op_pkg::*;

  localparam int NR  = 2;
  localparam int W   = 32;
  localparam int LAT = 1 + (4 + 3*W)*(3 + 1) + 4 - 1 + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic miso  = 1'b0;
  logic sclk, nss, mosi, busy;
  int   n_pass = 0;
  int   n_total = 0;

  spi_op_arbiter_if #(.NUM_REQ(NR), .REG_WIDTH(W)) bus();

  spi_op_arbiter #(
    .NUM_REQ(NR), .REG_WIDTH(W), .SCLK_LOW(3), .EXEC_GAP(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .sclk  (sclk),
    .nss   (nss),
    .mosi  (mosi),
    .miso  (miso),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu(
    logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_SHL:  return a << b[4:0];
      OP_SHR:  return a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  logic [67:0] s_sr;
  int          s_cnt, r_cnt;
  logic [31:0] s_res, cap_a, cap_b;
  logic [3:0]  cap_op;

  always @(negedge clock) begin
    if (nss) begin
      s_cnt = 0;
      r_cnt = 0;
      miso  = 1'b0;
    end else if (s_cnt < 68) begin
      if (sclk) begin
        s_sr = {s_sr[66:0], mosi};
        s_cnt++;
        if (s_cnt == 68) begin
          cap_op = s_sr[67:64];
          cap_a  = s_sr[63:32];
          cap_b  = s_sr[31:0];
          s_res  = alu(cap_op, cap_a, cap_b);
          miso   = s_res[31];
        end
      end
    end else begin
      if (sclk) r_cnt++;
      else if (r_cnt < 32) miso = s_res[31 - r_cnt];
    end
  end

  logic sclk_prev = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      n_total++;
      if ($countones(bus.req_ready) > 1)
        $display("FAIL mon_ready_onehot: got %b want onehot0",
                 bus.req_ready);
      else n_pass++;
      n_total++;
      if (sclk && sclk_prev)
        $display("FAIL mon_sclk_width: got high 2 cycles want 1");
      else n_pass++;
      n_total++;
      if (!nss && !busy)
        $display("FAIL mon_nss: got nss low while idle want high");
      else n_pass++;
    end
    sclk_prev = sclk;
  end

  task automatic wait_grant(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 1000) begin
      @(negedge clock);
      if (bus.req_ready != '0) ok = 1'b1;
      else cyc++;
    end
  endtask

  task automatic wait_rsp(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      ok = bus.rsp_valid;
    end
  endtask

  task automatic test_reset();
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    reset = 1'b1;
    @(negedge clock);
    n_total++;
    if (nss !== 1'b1) $display("FAIL rst_nss: got %b want 1", nss);
    else n_pass++;
    n_total++;
    if (sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", sclk);
    else n_pass++;
    n_total++;
    if (mosi !== 1'b0) $display("FAIL rst_mosi: got %b want 0", mosi);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL rst_ready: got %b want 00", bus.req_ready);
    else n_pass++;
    n_total++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid);
    else n_pass++;
    n_total++;
    if (bus.rsp_id !== 1'b0)
      $display("FAIL rst_rsp_id: got %h want 0", bus.rsp_id);
    else n_pass++;
    n_total++;
    if (bus.rsp_data !== 32'h0)
      $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data);
    else n_pass++;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    int cyc;
    bit ok;
    @(posedge clock);
    #1;
    bus.req_opcode[0] = OP_SHL;
    bus.req_a[0]      = 32'h0000_0001;
    bus.req_b[0]      = 32'h0000_0004;
    bus.req_valid     = 2'b01;
    @(negedge clock);
    n_total++;
    if (bus.req_ready !== 2'b01)
      $display("FAIL single_grant: got %b want 01", bus.req_ready);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy);
    else n_pass++;
    @(posedge clock);
    #1 bus.req_valid = 2'b00;
    wait_rsp(cyc, ok);
    n_total++;
    if (!ok || cyc != LAT)
      $display("FAIL single_latency: got %0d want %0d", cyc, LAT);
    else n_pass++;
    n_total++;
    if (bus.rsp_id !== 1'b0)
      $display("FAIL single_id: got %h want 0", bus.rsp_id);
    else n_pass++;
    n_total++;
    if (bus.rsp_data !== 32'h0000_0010)
      $display("FAIL single_data: got %h want 00000010", bus.rsp_data);
    else n_pass++;
    n_total++;
    if (nss !== 1'b1) $display("FAIL single_done_nss: got %b want 1", nss);
    else n_pass++;
    @(posedge clock);
    #1 bus.req_valid = 2'b01;
    @(negedge clock);
    n_total++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL single_pulse: got %b want 0", bus.rsp_valid);
    else n_pass++;
    n_total++;
    if (bus.rsp_data !== 32'h0000_0010)
      $display("FAIL single_hold: got %h want 00000010", bus.rsp_data);
    else n_pass++;
    n_total++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL single_guard1: got %b want 00", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL single_guard2: got %b want 00", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (bus.req_ready !== 2'b01)
      $display("FAIL single_regrant: got %b want 01", bus.req_ready);
    else n_pass++;
    @(posedge clock);
    #1 bus.req_valid = 2'b00;
    wait_rsp(cyc, ok);
    n_total++;
    if (!ok || bus.rsp_data !== 32'h0000_0010)
      $display("FAIL single_again: got %h want 00000010", bus.rsp_data);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int cyc;
    bit ok;
    logic [1:0]  exp_rdy;
    logic        exp_id;
    logic [31:0] exp_d;
    bus.req_valid = 2'b00;
    reset = 1'b1;
    bus.req_opcode[0] = OP_SHL;
    bus.req_a[0]      = 32'h3;
    bus.req_b[0]      = 32'h2;
    bus.req_opcode[1] = OP_SHR;
    bus.req_a[1]      = 32'hF0;
    bus.req_b[1]      = 32'h4;
    bus.req_valid     = 2'b11;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_id  = (k == 1);
      exp_rdy = exp_id ? 2'b10 : 2'b01;
      exp_d   = exp_id ? 32'hF : 32'hC;
      wait_grant(cyc, ok);
      n_total++;
      if (!ok || bus.req_ready !== exp_rdy)
        $display("FAIL rr_grant%0d: got %b want %b",
                 k, bus.req_ready, exp_rdy);
      else n_pass++;
      wait_rsp(cyc, ok);
      n_total++;
      if (!ok || bus.rsp_id !== exp_id)
        $display("FAIL rr_id%0d: got %h want %h", k, bus.rsp_id, exp_id);
      else n_pass++;
      n_total++;
      if (bus.rsp_data !== exp_d)
        $display("FAIL rr_data%0d: got %h want %h",
                 k, bus.rsp_data, exp_d);
      else n_pass++;
    end
    @(posedge clock);
    #1 bus.req_valid = 2'b00;
  endtask

  task automatic run_op0(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cyc,
                         output bit ok);
    @(posedge clock);
    #1;
    bus.req_opcode[0] = op;
    bus.req_a[0]      = a;
    bus.req_b[0]      = b;
    bus.req_valid     = 2'b01;
    wait_grant(cyc, ok);
    @(posedge clock);
    #1 bus.req_valid = 2'b00;
    if (ok) wait_rsp(cyc, ok);
  endtask

  task automatic test_shr_stream();
    int cyc;
    bit ok;
    run_op0(OP_SHR, 32'h8000_0000, 32'h0000_001F, cyc, ok);
    n_total++;
    if (!ok || bus.rsp_data !== 32'h0000_0001)
      $display("FAIL shr_data: got %h want 00000001", bus.rsp_data);
    else n_pass++;
    n_total++;
    if (cap_op !== 4'b0111)
      $display("FAIL shr_mosi_op: got %b want 0111", cap_op);
    else n_pass++;
    n_total++;
    if (cap_a !== 32'h8000_0000)
      $display("FAIL shr_mosi_a: got %h want 80000000", cap_a);
    else n_pass++;
    n_total++;
    if (cap_b !== 32'h0000_001F)
      $display("FAIL shr_mosi_b: got %h want 0000001f", cap_b);
    else n_pass++;
  endtask

  task automatic test_unknown_op();
    int cyc;
    bit ok;
    run_op0(4'b1010, 32'h0F0F_0000, 32'h00F0_F0F0, cyc, ok);
    n_total++;
    if (cap_op !== 4'b1010)
      $display("FAIL unk_op: got %b want 1010", cap_op);
    else n_pass++;
    n_total++;
    if (!ok || bus.rsp_data !== 32'h0FFF_F0F0)
      $display("FAIL unk_data: got %h want 0ffff0f0", bus.rsp_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    @(posedge clock);
    #1;
    bus.req_opcode[0] = OP_SHL;
    bus.req_a[0]      = 32'h1234;
    bus.req_b[0]      = 32'h1;
    bus.req_valid     = 2'b01;
    wait_grant(cyc, ok);
    @(posedge clock);
    #1 bus.req_valid = 2'b00;
    repeat (30) @(negedge clock);
    cyc = 0;
    while (!sclk && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    n_total++;
    if (sclk !== 1'b1 || nss !== 1'b0)
      $display("FAIL rm_pre: got sclk %b nss %b want 1 0", sclk, nss);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++;
    if (nss !== 1'b1) $display("FAIL rm_nss: got %b want 1", nss);
    else n_pass++;
    n_total++;
    if (sclk !== 1'b0) $display("FAIL rm_sclk: got %b want 0", sclk);
    else n_pass++;
    n_total++;
    if (mosi !== 1'b0) $display("FAIL rm_mosi: got %b want 0", mosi);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL rm_busy: got %b/%b want 0/0", busy, bus.rsp_valid);
    else n_pass++;
    @(posedge clock);
    #1;
    bus.req_opcode[0] = OP_SHL;
    bus.req_a[0]      = 32'h5;
    bus.req_b[0]      = 32'h8;
    bus.req_valid     = 2'b11;
    reset = 1'b0;
    wait_grant(cyc, ok);
    n_total++;
    if (!ok || bus.req_ready !== 2'b01)
      $display("FAIL rm_ptr: got %b want 01", bus.req_ready);
    else n_pass++;
    @(posedge clock);
    #1 bus.req_valid = 2'b00;
    wait_rsp(cyc, ok);
    n_total++;
    if (!ok || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h500)
      $display("FAIL rm_after: got %h/%h want 0/00000500",
               bus.rsp_id, bus.rsp_data);
    else n_pass++;
  endtask

  task automatic test_drop();
    int cyc;
    bit ok;
    @(posedge clock);
    #1;
    bus.req_opcode[1] = OP_SHL;
    bus.req_a[1]      = 32'h0000_ABCD;
    bus.req_b[1]      = 32'h10;
    bus.req_valid     = 2'b10;
    wait_grant(cyc, ok);
    n_total++;
    if (!ok || bus.req_ready !== 2'b10)
      $display("FAIL drop_grant: got %b want 10", bus.req_ready);
    else n_pass++;
    @(posedge clock);
    #1;
    bus.req_valid     = 2'b00;
    bus.req_opcode[1] = 4'hF;
    bus.req_a[1]      = 32'hDEAD_BEEF;
    bus.req_b[1]      = 32'h3;
    wait_rsp(cyc, ok);
    n_total++;
    if (!ok || bus.rsp_id !== 1'b1)
      $display("FAIL drop_id: got %h want 1", bus.rsp_id);
    else n_pass++;
    n_total++;
    if (bus.rsp_data !== 32'hABCD_0000)
      $display("FAIL drop_data: got %h want abcd0000", bus.rsp_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_shr_stream();
    test_unknown_op();
    test_reset_mid();
    test_drop();
    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_op_arbiter.md
SPI_OP_ARBITER -- requirements
Module: spi_op_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, number of requesters (2..4).
REQ-002 The block SHALL have parameter REG_WIDTH, default 32, operand/result width.
REQ-003 The block SHALL have parameter SCLK_LOW, default 3, clock cycles sclk is held low per bit (>=2); sclk high is always exactly 1 cycle.
REQ-004 The block SHALL have parameter EXEC_GAP, default 4, idle clocks with nss low between last B bit and first result bit.
REQ-005 The block SHALL have port clock  input  1  system clock.
REQ-006 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have ports req_valid / req_ready  input / output  NUM_REQ  per-requester handshake.
REQ-008 The block SHALL have ports req_opcode / req_a / req_b  input  NUM_REQ x 4 / x REG_WIDTH / x REG_WIDTH  per-requester operation.
REQ-009 The block SHALL have ports rsp_valid / rsp_id / rsp_data  output  1 / clog2(NUM_REQ) / REG_WIDTH  completion pulse, owner, result.
REQ-010 The block SHALL have ports sclk, nss, mosi  output  1  and miso  input  1  SPI master link to the shared shift/ALU slave.
REQ-011 The block SHALL have port busy  output  1  high from grant until rsp_valid.

Function
REQ-012 The FSM SHALL use states IDLE, SEND_OP, SEND_A, SEND_B, EXEC_WAIT, RECV, DONE, GUARD.
REQ-013 In IDLE with any req_valid high, the block SHALL grant round-robin starting at the index after the last granted one (index 0 first after reset), pulse req_ready for that requester for exactly 1 cycle, capture opcode/a/b in the same cycle, and enter SEND_OP next cycle.
REQ-014 req_ready SHALL never be high for more than one requester or outside IDLE; requests arriving while busy SHALL wait (req_valid held by requester).
REQ-015 nss SHALL go low on entry to SEND_OP and stay low through RECV.
REQ-016 Each bit SHALL occupy SCLK_LOW+1 cycles: mosi updated at start of low phase, sclk high on final cycle; bits MSB first.
REQ-017 SEND_OP SHALL shift 4 bits, SEND_A and SEND_B REG_WIDTH bits each; bit counter (6-bit) resets to 0 on each state change.
REQ-018 EXEC_WAIT SHALL hold sclk low, mosi 0 for EXEC_GAP cycles.
REQ-019 RECV SHALL generate REG_WIDTH bit periods, sampling miso in the cycle sclk is high, shifting MSB first into the result register.
REQ-020 In DONE (1 cycle) rsp_valid SHALL be 1, rsp_id = granted index, rsp_data = received result; nss SHALL return high.
REQ-021 GUARD SHALL hold nss high for 2 cycles before returning to IDLE; total transaction = 1 + (68+REG_WIDTH... i.e. (4+3*REG_WIDTH)*(SCLK_LOW+1) + EXEC_GAP + 1 + 2 cycles after grant.
REQ-022 A requester dropping req_valid after grant SHALL not affect the transaction.
REQ-023 rsp_data/rsp_id SHALL hold last value after DONE; rsp_valid SHALL be 0 outside DONE.
REQ-024 Opcode values are not interpreted; unknown opcodes are forwarded unchanged.

Reset
REQ-025 On reset (asynchronous, any state incl. mid-transfer) the block SHALL force IDLE, nss=1, sclk=0, mosi=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, RR pointer so index 0 is next.
REQ-026 Deassertion SHALL take effect on the next clock edge; no partial result is reported.

Structure
REQ-027 Package spi_op_pkg SHALL hold the state enum, OP_SHL=4'b0110, OP_SHR=4'b0111, OPCODE_W=4 shared with the slave.
REQ-028 One sub-module spi_bit_engine (bit timing, shift register, counter) SHALL be instantiated; arbitration/FSM remain in the top.

Verification
REQ-029 Single request id0 op=0110 A=0x00000001 B=0x00000004, slave model -> one rsp_valid, rsp_id=0, rsp_data=0x00000010, exact cycle count per REQ-021.
REQ-030 req_valid[0] and [1] both high from reset -> grants 0 then 1; then both high again -> 0 (RR after 1); responses in grant order.
REQ-031 op=0111 A=0x80000000 B=0x0000001F -> rsp_data=0x00000001; mosi bitstream checked: 0111, A, B MSB first.
REQ-032 Reset asserted mid SEND_A -> nss=1, sclk=0 same cycle (async); next request completes correctly.
REQ-033 req_valid[1] dropped immediately after its req_ready pulse -> transaction still completes with rsp_id=1.
REQ-034 Monitor: req_ready one-hot or zero, sclk high exactly 1 cycle, nss never low outside SEND_OP..RECV.
